// File: rtl/lab5_fetch_pkg.sv
// Shared widths, PC step and queue entry type for the lab5 instruction fetch front end.
package lab5_fetch_pkg;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 16;
  localparam int PC_STEP = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;

  // Instructions are halfword aligned, so the PC never carries bit 0.
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
    return pc & ~ADDR_W'(1);
  endfunction

endpackage

// File: rtl/lab5_fetch_queue.sv
// Small synchronous FIFO of {pc, instr} entries with flush; async active-low reset.
module lab5_fetch_queue
  import lab5_fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               flush,
  input  logic               push,
  input  logic               pop,
  input  fetch_entry_t       wr_entry,
  output fetch_entry_t       rd_entry,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty
);

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             do_push, do_pop;

  fetch_entry_t mem [DEPTH];

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CNT_W'(DEPTH));
  assign count = count_reg;

  // A full queue still takes a write when the head leaves in the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (do_push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      if (do_push && !do_pop)
        count_next = count_reg + CNT_W'(1);
      else if (!do_push && do_pop)
        count_next = count_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push && !flush)
      mem[wr_ptr_reg] <= wr_entry;
  end

  // Empty head reads as zero so stale storage never shows on the outputs.
  assign rd_entry = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/lab5_ifetch.sv
// Instruction fetch front end: PC sequencing, redirect flush and decode handshake.
// Optional zero-word halt detection is enabled by defining IFETCH_HALT_DETECT_EN.
module lab5_ifetch
  import lab5_fetch_pkg::*;
#(
  parameter  int                        DEPTH    = 4,
  parameter  int                        ADDR_W   = lab5_fetch_pkg::ADDR_W,
  parameter  int                        DATA_W   = lab5_fetch_pkg::DATA_W,
  parameter  logic [ADDR_W-1:0]         RESET_PC = '0,
  localparam int                        CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RESET,
  output logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] Q,
  output logic [DATA_W-1:0] INSTR,
  output logic [ADDR_W-1:0] INSTR_PC,
  output logic              INSTR_VALID,
  input  logic              INSTR_READY,
  input  logic              REDIRECT,
  input  logic [ADDR_W-1:0] REDIRECT_PC,
  output logic [CNT_W-1:0]  OCCUPANCY,
  output logic              HALTED
);

  logic [ADDR_W-1:0] fpc_reg, fpc_next;
  logic              halted_reg;
  logic              pop, push_cand, push, halt_hit;
  logic              q_full, q_empty;
  fetch_entry_t      head_entry, tail_entry;

  assign pop = INSTR_VALID && INSTR_READY;

  // Redirect wins: no push that edge, and a halted fetcher stays parked.
  assign push_cand = !REDIRECT && !halted_reg && (!q_full || pop);

`ifdef IFETCH_HALT_DETECT_EN
  logic halted_next;

  assign halt_hit = push_cand && (Q == '0);

  always_comb begin
    halted_next = halted_reg;
    if (REDIRECT)
      halted_next = 1'b0;
    else if (halt_hit)
      halted_next = 1'b1;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)
      halted_reg <= 1'b0;
    else
      halted_reg <= halted_next;
  end
`else
  assign halt_hit   = 1'b0;
  assign halted_reg = 1'b0;
`endif

  assign push = push_cand && !halt_hit;

  always_comb begin
    fpc_next = fpc_reg;
    if (REDIRECT)
      fpc_next = align_pc(REDIRECT_PC);
    else if (push)
      fpc_next = fpc_reg + ADDR_W'(PC_STEP);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)
      fpc_reg <= align_pc(RESET_PC);
    else
      fpc_reg <= fpc_next;
  end

  assign tail_entry.pc    = fpc_reg;
  assign tail_entry.instr = Q;

  lab5_fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .CLK      (CLK),
    .RESET    (RESET),
    .flush    (REDIRECT),
    .push     (push),
    .pop      (pop),
    .wr_entry (tail_entry),
    .rd_entry (head_entry),
    .count    (OCCUPANCY),
    .full     (q_full),
    .empty    (q_empty)
  );

  assign ADDR        = fpc_reg;
  assign INSTR       = head_entry.instr;
  assign INSTR_PC    = head_entry.pc;
  assign INSTR_VALID = !q_empty;
  assign HALTED      = halted_reg;

endmodule

// File: tb/tb_lab5_ifetch.sv
// Directed table-driven bench for lab5_ifetch with hand-written redirect/halt/reset sequences.
module tb_lab5_ifetch;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [7:0]  ADDR;
  logic [15:0] Q;
  logic [15:0] INSTR;
  logic [7:0]  INSTR_PC;
  logic        INSTR_VALID;
  logic        INSTR_READY = 1'b0;
  logic        REDIRECT = 1'b0;
  logic [7:0]  REDIRECT_PC = 8'h00;
  logic [2:0]  OCCUPANCY;
  logic        HALTED;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [7:0]  rpc;
    logic        valid;
    logic [15:0] instr;
    logic [7:0]  pc;
    logic [7:0]  addr;
    logic [2:0]  occ;
    logic        halt;
  } vec_t;

  vec_t vt[$];

  lab5_ifetch dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .ADDR        (ADDR),
    .Q           (Q),
    .INSTR       (INSTR),
    .INSTR_PC    (INSTR_PC),
    .INSTR_VALID (INSTR_VALID),
    .INSTR_READY (INSTR_READY),
    .REDIRECT    (REDIRECT),
    .REDIRECT_PC (REDIRECT_PC),
    .OCCUPANCY   (OCCUPANCY),
    .HALTED      (HALTED)
  );

  always #5 CLK = ~CLK;

  // Program: word n at byte 2n; w0..w2 and w26 fixed, w3..w25 = A000|n, rest zero.
  function automatic logic [15:0] prog_word(input logic [7:0] a);
    logic [6:0] n;
    n = a[7:1];
    if (n == 7'd0)  return 16'hF001;
    if (n == 7'd1)  return 16'h517F;
    if (n == 7'd2)  return 16'h2A79;
    if (n == 7'd26) return 16'h4B00;
    if (n <= 7'd25) return {8'hA0, 1'b0, n};
    return 16'h0000;
  endfunction

  assign Q = prog_word(ADDR);

  function automatic vec_t mk(input logic rdy, input logic redir, input logic [7:0] rpc,
                              input logic v, input logic [15:0] ins, input logic [7:0] pc,
                              input logic [7:0] addr, input logic [2:0] occ, input logic h);
    vec_t r;
    r.rdy = rdy; r.redir = redir; r.rpc = rpc; r.valid = v; r.instr = ins;
    r.pc = pc; r.addr = addr; r.occ = occ; r.halt = h;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    INSTR_READY = 1'b0;
    REDIRECT    = 1'b0;
    RESET       = 1'b0;
    step();
    RESET       = 1'b1;
  endtask

  task automatic apply_rows(input int lo, input int hi, input string tag);
    for (int i = lo; i <= hi; i++) begin
      INSTR_READY = vt[i].rdy;
      REDIRECT    = vt[i].redir;
      REDIRECT_PC = vt[i].rpc;
      step();
      REDIRECT = 1'b0;
      $display("%s row %0d: addr=%0h valid=%0b pc=%0h instr=%0h occ=%0d halted=%0b",
               tag, i, ADDR, INSTR_VALID, INSTR_PC, INSTR, OCCUPANCY, HALTED);
      chk({tag, "_valid"}, 32'(INSTR_VALID), 32'(vt[i].valid));
      chk({tag, "_addr"},  32'(ADDR),        32'(vt[i].addr));
      chk({tag, "_occ"},   32'(OCCUPANCY),   32'(vt[i].occ));
      chk({tag, "_halt"},  32'(HALTED),      32'(vt[i].halt));
      if (vt[i].valid) begin
        chk({tag, "_pc"},    32'(INSTR_PC), 32'(vt[i].pc));
        chk({tag, "_instr"}, 32'(INSTR),    32'(vt[i].instr));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  last_pc;
    logic [15:0] last_instr;
    logic        done;

    // T1 rows 0..2: reset release with decode always ready
    vt.push_back(mk(1, 0, 8'h00, 1, 16'hF001, 8'h00, 8'h02, 3'd1, 0));
    vt.push_back(mk(1, 0, 8'h00, 1, 16'h517F, 8'h02, 8'h04, 3'd1, 0));
    vt.push_back(mk(1, 0, 8'h00, 1, 16'h2A79, 8'h04, 8'h06, 3'd1, 0));
    // T2 rows 3..16: stall 10 cycles, then drain in order
    for (int k = 1; k <= 10; k++)
      vt.push_back(mk(0, 0, 8'h00, 1, 16'hF001, 8'h00,
                      (k >= 4) ? 8'h08 : 8'(2 * k), (k >= 4) ? 3'd4 : 3'(k), 0));
    vt.push_back(mk(1, 0, 8'h00, 1, 16'h517F, 8'h02, 8'h0A, 3'd4, 0));
    vt.push_back(mk(1, 0, 8'h00, 1, 16'h2A79, 8'h04, 8'h0C, 3'd4, 0));
    vt.push_back(mk(1, 0, 8'h00, 1, 16'hA003, 8'h06, 8'h0E, 3'd4, 0));
    vt.push_back(mk(1, 0, 8'h00, 1, 16'hA004, 8'h08, 8'h10, 3'd4, 0));
    // T3 rows 17..18: redirect a full queue to odd 0x35
    vt.push_back(mk(0, 1, 8'h35, 0, 16'h0000, 8'h00, 8'h34, 3'd0, 0));
    vt.push_back(mk(0, 0, 8'h00, 1, 16'h4B00, 8'h34, 8'h36, 3'd1, 0));
    // T4 rows 19..21: redirect to FE and wrap (word at FE is zero)
    vt.push_back(mk(1, 1, 8'hFE, 0, 16'h0000, 8'h00, 8'hFE, 3'd0, 0));
`ifdef IFETCH_HALT_DETECT_EN
    vt.push_back(mk(1, 0, 8'h00, 0, 16'h0000, 8'h00, 8'hFE, 3'd0, 1));
    vt.push_back(mk(1, 0, 8'h00, 0, 16'h0000, 8'h00, 8'hFE, 3'd0, 1));
`else
    vt.push_back(mk(1, 0, 8'h00, 1, 16'h0000, 8'hFE, 8'h00, 3'd1, 0));
    vt.push_back(mk(1, 0, 8'h00, 1, 16'hF001, 8'h00, 8'h02, 3'd1, 0));
`endif

    // Reset state
    #1 RESET = 1'b0;
    #1;
    chk("rst_valid", 32'(INSTR_VALID), 32'd0);
    chk("rst_occ",   32'(OCCUPANCY),   32'd0);
    chk("rst_addr",  32'(ADDR),        32'h00);
    chk("rst_instr", 32'(INSTR),       32'h0000);
    chk("rst_pc",    32'(INSTR_PC),    32'h00);
    chk("rst_halt",  32'(HALTED),      32'd0);

    do_reset();
    chk("t1_addr0", 32'(ADDR), 32'h00);
    apply_rows(0, 2, "t1");

    do_reset();
    apply_rows(3, 16, "t2");
    apply_rows(17, 18, "t3");
    apply_rows(19, 21, "t4");

    // T5: free run from reset until the end of the program
    do_reset();
    INSTR_READY = 1'b1;
    last_pc    = 8'h00;
    last_instr = 16'hFFFF;
    done       = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      step();
      if (INSTR_VALID) begin
        last_pc    = INSTR_PC;
        last_instr = INSTR;
      end
`ifdef IFETCH_HALT_DETECT_EN
      if (HALTED) done = 1'b1;
`else
      if (INSTR_VALID && INSTR_PC == 8'h36) done = 1'b1;
`endif
    end
    $display("t5 run: done=%0b last_pc=%0h last_instr=%0h addr=%0h halted=%0b",
             done, last_pc, last_instr, ADDR, HALTED);
    chk("t5_reached_end", 32'(done), 32'd1);
`ifdef IFETCH_HALT_DETECT_EN
    chk("t5_last_pc", 32'(last_pc), 32'h34);
    chk("t5_halted",  32'(HALTED),  32'd1);
    chk("t5_addr",    32'(ADDR),    32'h36);
    step(); step(); step();
    chk("t5_addr_hold",  32'(ADDR),        32'h36);
    chk("t5_halt_hold",  32'(HALTED),      32'd1);
    chk("t5_empty",      32'(INSTR_VALID), 32'd0);
    REDIRECT = 1'b1; REDIRECT_PC = 8'h00;
    step();
    REDIRECT = 1'b0;
    chk("t5_unhalt",     32'(HALTED), 32'd0);
    chk("t5_redir_addr", 32'(ADDR),   32'h00);
    step();
    chk("t5_restart_valid", 32'(INSTR_VALID), 32'd1);
    chk("t5_restart_pc",    32'(INSTR_PC),    32'h00);
    chk("t5_restart_instr", 32'(INSTR),       32'hF001);
`else
    chk("t5_last_pc",    32'(last_pc),    32'h36);
    chk("t5_last_instr", 32'(last_instr), 32'h0000);
    chk("t5_halted",     32'(HALTED),     32'd0);
`endif

    // T6: asynchronous reset between edges with three entries queued
    do_reset();
    INSTR_READY = 1'b0;
    step(); step(); step();
    chk("t6_occ_before", 32'(OCCUPANCY), 32'd3);
    #2 RESET = 1'b0;
    #1;
    $display("t6 async reset: addr=%0h valid=%0b occ=%0d", ADDR, INSTR_VALID, OCCUPANCY);
    chk("t6_valid", 32'(INSTR_VALID), 32'd0);
    chk("t6_occ",   32'(OCCUPANCY),   32'd0);
    chk("t6_addr",  32'(ADDR),        32'h00);
    chk("t6_instr", 32'(INSTR),       32'h0000);
    chk("t6_halt",  32'(HALTED),      32'd0);
    step();
    RESET = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
